// File: rtl/writeback_buffer.sv
// Writeback buffer: queues ALU/MDU register writes into a small FIFO and
// drives one register file write per cycle. Optional forwarding: WB_FORWARD_EN.
module writeback_buffer #(
  parameter int DEPTH        = 4,
  parameter int BITS         = 32,
  parameter int WORDS        = 16,
  parameter int ADDRESS_BITS = $clog2(WORDS)
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [ADDRESS_BITS-1:0] alu_addr,
  input  logic [BITS-1:0]         alu_data,
  input  logic                    mdu_valid,
  output logic                    mdu_ready,
  input  logic [ADDRESS_BITS-1:0] mdu_addr,
  input  logic [BITS-1:0]         mdu_data,
  output logic [ADDRESS_BITS-1:0] addr_out,
  output logic [BITS-1:0]         data_out,
  output logic [WORDS-1:0]        pending,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
`ifdef WB_FORWARD_EN
  ,
  input  logic [ADDRESS_BITS-1:0] fwd_addr,
  output logic                    fwd_hit,
  output logic [BITS-1:0]         fwd_data
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDRESS_BITS-1:0] mem_addr [DEPTH];
  logic [BITS-1:0]         mem_data [DEPTH];

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] mdu_slot;
  logic [CW-1:0] free;
  logic [CW-1:0] npush;
  logic          pop;
  logic          alu_push;
  logic          mdu_push;
  logic          alu_fire;
  logic          mdu_fire;

  // A pop happens whenever the FIFO holds anything, so its slot is
  // reusable in the same cycle.
  assign pop  = (count != '0);
  assign free = CW'(DEPTH) - count + {{PW{1'b0}}, pop};

  // ALU wins; MDU needs a second slot when the ALU is also asking.
  assign alu_ready = clr && (free >= CW'(1));
  assign mdu_ready = clr && (alu_valid ? (free >= CW'(2))
                                       : (free >= CW'(1)));

  assign alu_fire = alu_valid && alu_ready;
  assign mdu_fire = mdu_valid && mdu_ready;

  // Writes to r0 are acknowledged but dropped.
  assign alu_push = alu_fire && (alu_addr != '0);
  assign mdu_push = mdu_fire && (mdu_addr != '0);

  assign npush    = {{PW{1'b0}}, alu_push} + {{PW{1'b0}}, mdu_push};
  assign mdu_slot = alu_push ? wptr + PW'(1) : wptr;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Entry storage; validity is tracked by the pointers and count only.
  always_ff @(posedge clk) begin
    if (clr) begin
      if (alu_push) begin
        mem_addr[wptr] <= alu_addr;
        mem_data[wptr] <= alu_data;
      end
      if (mdu_push) begin
        mem_addr[mdu_slot] <= mdu_addr;
        mem_data[mdu_slot] <= mdu_data;
      end
    end
  end

  // Pointers, occupancy and the output register feeding the register file.
  always_ff @(posedge clk) begin
    if (!clr) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      addr_out <= '0;
      data_out <= '0;
    end else begin
      wptr  <= wptr + PW'(npush);
      count <= count + npush - {{PW{1'b0}}, pop};
      if (pop) begin
        addr_out <= mem_addr[rptr];
        data_out <= mem_data[rptr];
        rptr     <= rptr + PW'(1);
      end else begin
        addr_out <= '0;
        data_out <= '0;
      end
    end
  end

  // Pending bitmap from live FIFO entries plus the output register.
  always_comb begin
    logic [PW-1:0] idx;
    pending = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr + PW'(i);
      if (CW'(i) < count)
        pending[mem_addr[idx]] = 1'b1;
    end
    pending[addr_out] = 1'b1;
    pending[0]        = 1'b0;
  end

`ifdef WB_FORWARD_EN
  // Youngest matching write wins: output register first, then FIFO
  // entries oldest to newest, each later match overriding.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    if (fwd_addr != '0) begin
      if (addr_out == fwd_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = data_out;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = rptr + PW'(i);
        if ((CW'(i) < count) && (mem_addr[idx] == fwd_addr)) begin
          fwd_hit  = 1'b1;
          fwd_data = mem_data[idx];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_writeback_buffer.sv
// Directed bench for writeback_buffer.
// Inputs change 1ns after a rising edge; outputs are checked at 2ns.
module tb_writeback_buffer;

  logic        clk = 1'b0;
  logic        clr;
  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  alu_addr;
  logic [31:0] alu_data;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [3:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic [3:0]  addr_out;
  logic [31:0] data_out;
  logic [15:0] pending;
  logic [2:0]  count;
  logic        empty;
  logic        full;
`ifdef WB_FORWARD_EN
  logic [3:0]  fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  int tests;
  int failed;

  always #5 clk = ~clk;

  writeback_buffer dut (
    .clk       (clk),
    .clr       (clr),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .mdu_valid (mdu_valid),
    .mdu_ready (mdu_ready),
    .mdu_addr  (mdu_addr),
    .mdu_data  (mdu_data),
    .addr_out  (addr_out),
    .data_out  (data_out),
    .pending   (pending),
    .count     (count),
    .empty     (empty),
    .full      (full)
`ifdef WB_FORWARD_EN
    ,
    .fwd_addr  (fwd_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data)
`endif
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag,
                         input logic [3:0] a,
                         input logic [31:0] d,
                         input logic [2:0] c);
    check({tag, ".addr"}, 64'(addr_out), 64'(a));
    check({tag, ".data"}, 64'(data_out), 64'(d));
    check({tag, ".count"}, 64'(count), 64'(c));
  endtask

  logic [3:0]  ea [9];
  logic [31:0] ed [9];
  logic [2:0]  ec [10];

  initial begin
    tests     = 0;
    failed    = 0;
    clr       = 1'b0;
    alu_valid = 1'b1;
    alu_addr  = 4'd5;
    alu_data  = 32'd1;
    mdu_valid = 1'b1;
    mdu_addr  = 4'd6;
    mdu_data  = 32'd2;
`ifdef WB_FORWARD_EN
    fwd_addr  = 4'd0;
`endif

    // reset held two cycles with requests asserted
    for (int k = 0; k < 2; k++) begin
      tick();
      #1;
      check("rst.alu_ready", 64'(alu_ready), 64'd0);
      check("rst.mdu_ready", 64'(mdu_ready), 64'd0);
      chk_out("rst", 4'd0, 32'd0, 3'd0);
      check("rst.pending", 64'(pending), 64'd0);
      check("rst.empty", 64'(empty), 64'd1);
      check("rst.full", 64'(full), 64'd0);
    end
    clr       = 1'b1;
    alu_valid = 1'b0;
    mdu_valid = 1'b0;
    tick();
    chk_out("idle", 4'd0, 32'd0, 3'd0);

    // single ALU write r11=853
    alu_valid = 1'b1;
    alu_addr  = 4'd11;
    alu_data  = 32'd853;
    #1;
    check("one.ready", 64'(alu_ready), 64'd1);
    tick();
    alu_valid = 1'b0;
    #1;
    chk_out("one.N", 4'd0, 32'd0, 3'd1);
    check("one.N.pend", 64'(pending), 64'h0800);
    tick();
    #1;
    chk_out("one.N1", 4'd11, 32'd853, 3'd0);
    check("one.N1.pend", 64'(pending), 64'h0800);
    tick();
    #1;
    chk_out("one.N2", 4'd0, 32'd0, 3'd0);
    check("one.N2.pend", 64'(pending), 64'h0000);

    // ALU and MDU together into an empty FIFO
    alu_valid = 1'b1;
    alu_addr  = 4'd4;
    alu_data  = 32'd124;
    mdu_valid = 1'b1;
    mdu_addr  = 4'd15;
    mdu_data  = 32'd888;
    #1;
    check("dual.alu_ready", 64'(alu_ready), 64'd1);
    check("dual.mdu_ready", 64'(mdu_ready), 64'd1);
    tick();
    alu_valid = 1'b0;
    mdu_valid = 1'b0;
    #1;
    chk_out("dual.e0", 4'd0, 32'd0, 3'd2);
    check("dual.pend", 64'(pending), 64'h8010);
    tick();
    #1;
    chk_out("dual.e1", 4'd4, 32'd124, 3'd1);
    tick();
    #1;
    chk_out("dual.e2", 4'd15, 32'd888, 3'd0);
    tick();
    #1;
    chk_out("dual.e3", 4'd0, 32'd0, 3'd0);

    // fill to full with MDU held valid, ALU every cycle for 4 cycles
    ea = '{4'd1, 4'd9, 4'd2, 4'd9, 4'd3, 4'd9, 4'd4, 4'd9, 4'd0};
    ed = '{32'd100, 32'd200, 32'd101, 32'd201, 32'd102,
           32'd202, 32'd103, 32'd204, 32'd0};
    ec = '{3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    mdu_valid = 1'b1;
    mdu_addr  = 4'd9;
    for (int k = 0; k < 5; k++) begin
      alu_valid = (k < 4);
      alu_addr  = 4'(k + 1);
      alu_data  = 32'(100 + k);
      mdu_data  = 32'(200 + k);
      #1;
      if (k == 3) begin
        check("fill.full", 64'(full), 64'd1);
        check("fill.mdu_block", 64'(mdu_ready), 64'd0);
        check("fill.alu_ok", 64'(alu_ready), 64'd1);
      end
      if (k == 4)
        check("fill.mdu_ok", 64'(mdu_ready), 64'd1);
      tick();
      #1;
      check($sformatf("fill.c%0d", k), 64'(count), 64'(ec[k]));
      if (k > 0) begin
        check($sformatf("fill.a%0d", k), 64'(addr_out), 64'(ea[k-1]));
        check($sformatf("fill.d%0d", k), 64'(data_out), 64'(ed[k-1]));
      end
    end
    alu_valid = 1'b0;
    mdu_valid = 1'b0;
    for (int k = 5; k < 10; k++) begin
      tick();
      #1;
      check($sformatf("drain.c%0d", k), 64'(count), 64'(ec[k]));
      check($sformatf("drain.a%0d", k), 64'(addr_out), 64'(ea[k-1]));
      check($sformatf("drain.d%0d", k), 64'(data_out), 64'(ed[k-1]));
      if (k == 8)
        check("drain.pend9", 64'(pending), 64'h0200);
    end
    check("drain.empty", 64'(empty), 64'd1);
    check("drain.pend", 64'(pending), 64'h0000);

    // write to r0 is acknowledged and dropped
    alu_valid = 1'b1;
    alu_addr  = 4'd0;
    alu_data  = 32'd999;
    #1;
    check("r0.ready", 64'(alu_ready), 64'd1);
    tick();
    alu_valid = 1'b0;
    #1;
    chk_out("r0.e0", 4'd0, 32'd0, 3'd0);
    check("r0.pend", 64'(pending), 64'h0000);
    tick();
    #1;
    chk_out("r0.e1", 4'd0, 32'd0, 3'd0);

`ifdef WB_FORWARD_EN
    // forwarding picks the youngest write to r7
    alu_valid = 1'b1;
    alu_addr  = 4'd7;
    alu_data  = 32'd5;
    tick();
    alu_data  = 32'd9;
    fwd_addr  = 4'd7;
    #1;
    check("fwd.e0.hit", 64'(fwd_hit), 64'd1);
    check("fwd.e0.data", 64'(fwd_data), 64'd5);
    tick();
    alu_valid = 1'b0;
    #1;
    check("fwd.e1.hit", 64'(fwd_hit), 64'd1);
    check("fwd.e1.data", 64'(fwd_data), 64'd9);
    fwd_addr = 4'd0;
    #1;
    check("fwd.r0.hit", 64'(fwd_hit), 64'd0);
    check("fwd.r0.data", 64'(fwd_data), 64'd0);
    fwd_addr = 4'd7;
    tick();
    #1;
    check("fwd.e2.hit", 64'(fwd_hit), 64'd1);
    check("fwd.e2.data", 64'(fwd_data), 64'd9);
    tick();
    #1;
    check("fwd.e3.hit", 64'(fwd_hit), 64'd0);
`endif

    // mid-stream reset discards queued entries
    alu_valid = 1'b1;
    alu_addr  = 4'd3;
    alu_data  = 32'd33;
    mdu_valid = 1'b1;
    mdu_addr  = 4'd2;
    mdu_data  = 32'd22;
    tick();
    alu_valid = 1'b0;
    mdu_valid = 1'b0;
    clr       = 1'b0;
    tick();
    #1;
    chk_out("mrst", 4'd0, 32'd0, 3'd0);
    check("mrst.pend", 64'(pending), 64'h0000);
    clr = 1'b1;
    tick();
    #1;
    chk_out("mrst.after", 4'd0, 32'd0, 3'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/writeback_buffer.md
Name: writeback_buffer

Overview:
- Upstream stage of the 16x32 register file. Collects register writebacks from the single-cycle ALU and the multi-cycle multiply/divide unit (MDU).
- Queues them in a small FIFO. Drives exactly one write per cycle onto the register file's data_in/addr_in pair.
- Also exports a per-register pending bitmap that the decode stage uses for hazard stalls.
- The register file has no write enable. When idle, this block drives address 0 with data 0, which keeps r0 at zero.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- BITS, 32, data width.
- WORDS, 16, register count.
- ADDRESS_BITS, $clog2(WORDS), register address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  reset; synchronous, active-low.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU request accepted this cycle.
- alu_addr  in  ADDRESS_BITS  ALU destination register.
- alu_data  in  BITS  ALU result.
- mdu_valid  in  1  MDU writeback request.
- mdu_ready  out  1  MDU request accepted this cycle.
- mdu_addr  in  ADDRESS_BITS  MDU destination register.
- mdu_data  in  BITS  MDU result.
- addr_out  out  ADDRESS_BITS  to register file addr_in.
- data_out  out  BITS  to register file data_in.
- pending  out  WORDS  bit i set while a write to ri is queued or in the output register.
- count  out  $clog2(DEPTH)+1  occupied FIFO entries.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

Behaviour:
- Reset: clr low at a rising edge clears the following. In-flight entries are discarded; no partial write is emitted.
  - count, read/write pointers = 0
  - addr_out = 0, data_out = 0
  - pending = 0
  - empty = 1, full = 0
- alu_ready and mdu_ready are 0 in any cycle where clr is low.
- Dequeue:
  - Each edge with count > 0: head is popped into the output register (addr_out/data_out).
  - Each edge with count == 0: output register loads 0/0.
  - The register file captures the output register on the following edge.
  - Minimum latency from accept edge N: addr_out valid after edge N+1, register written at edge N+2.
- Free space: free = DEPTH - count + (count > 0 ? 1 : 0), i.e. same-cycle pop frees a slot. Computed combinationally.
- Acceptance and priority:
  - ALU has priority: alu_ready = (free >= 1).
  - mdu_ready = (free >= 2) if alu_valid, else (free >= 1).
  - A request completes when valid & ready at the edge. Both may complete in one cycle; the ALU entry is enqueued ahead of the MDU entry.
- Address-0 writes: accepted (ready as above) but not stored. They do not change count or pending.
- Pointers wrap modulo DEPTH. Simultaneous push and pop on a full FIFO is legal: count is unchanged.
- pending:
  - Recomputed each edge from the valid FIFO entries plus the output register after the update.
  - Multiple writes to the same register keep the bit set until the last one leaves the output register.
  - pending[0] is always 0.
- Ordering: strict FIFO. Register file write order equals acceptance order.

Optional Feature:
- Macro: WB_FORWARD_EN.
- When defined, three ports are added:
  - fwd_addr  in  ADDRESS_BITS
  - fwd_hit  out  1
  - fwd_data  out  BITS
- Forwarding behaviour (combinational):
  - fwd_hit = 1 if any valid FIFO entry or the output register targets fwd_addr.
  - fwd_data is the value of the youngest such entry (newest FIFO entry first, output register last).
  - fwd_addr == 0 always gives fwd_hit = 0, fwd_data = 0.
- When not defined: the ports are absent and no compare logic is synthesized.

Test Plan:
- Reset with clr=0 for 2 cycles while alu_valid=1 → alu_ready=0; addr_out=0, data_out=0, pending=0, empty=1 throughout.
- ALU writes r11=853 at edge N → addr_out=11, data_out=853 after edge N+1; pending[11]=1 until after edge N+2; addr_out=0 after edge N+2.
- ALU r4=124 and MDU r15=888 valid in the same cycle into an empty FIFO → both accepted; outputs r4=124 then r15=888 on consecutive cycles; count peaks at 2.
- Hold mdu_valid with ALU writes every cycle until full → count reaches 4; mdu_ready=0 while alu_valid && free < 2; MDU accepted the first cycle alu_valid drops.
- ALU write to r0 with data 999 → alu_ready=1; count unchanged; addr_out stays 0; pending[0]=0.
- WB_FORWARD_EN defined; queue r7=5 then r7=9; fwd_addr=7 → fwd_hit=1, fwd_data=9; after both drain → fwd_hit=0.
